// File: rtl/ofmap_packetizer.sv
// Ofmap packet transmitter: turns a raster stream of partial sums into 40-bit
// tagged packets (row, col, timestep, layer, saturated psum), one frame per start.
module ofmap_packetizer #(
  parameter int PACKET_D_WIDTH = 40,
  parameter int ADDR_WIDTH     = 5,
  parameter int WIDTH_I        = 16,
  parameter int WIDTH_O        = 13,
  parameter int DEPTH_R        = 21
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                ts_in,
  input  logic [1:0]                layer_in,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH_I-1:0]        in_psum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PACKET_D_WIDTH-1:0] out_data
);

  localparam int TOTAL = DEPTH_R * DEPTH_R;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PAD_W = PACKET_D_WIDTH - 2 * ADDR_WIDTH - 4 - WIDTH_O;
  localparam logic [WIDTH_I-1:0]    SAT_MAX  = WIDTH_I'((1 << WIDTH_O) - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(DEPTH_R - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     row_q, row_d;
  logic [ADDR_WIDTH-1:0]     col_q, col_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                ts_q, ts_d;
  logic [1:0]                layer_q, layer_d;
  logic                      out_valid_q, out_valid_d;
  logic [PACKET_D_WIDTH-1:0] out_data_q, out_data_d;

  logic                      in_fire;
  logic                      out_fire;
  logic [WIDTH_O-1:0]        psum_sat;
  logic [PACKET_D_WIDTH-1:0] packet;

  // The output register may refill in the same cycle it empties, so a full
  // frame streams at one packet per cycle when downstream never stalls.
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign psum_sat = (in_psum > SAT_MAX) ? WIDTH_O'(SAT_MAX) : in_psum[WIDTH_O-1:0];
  assign packet   = {row_q, col_q, ts_q, layer_q, {PAD_W{1'b0}}, psum_sat};

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    ts_d        = ts_q;
    layer_d     = layer_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ts_d    = ts_in;
          layer_d = layer_in;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
        end
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = packet;
          cnt_d       = cnt_q + CNT_W'(1);
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + ADDR_WIDTH'(1);
          end else begin
            col_d = col_q + ADDR_WIDTH'(1);
          end
          if (cnt_q == LAST_CNT) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      ts_q        <= '0;
      layer_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      ts_q        <= ts_d;
      layer_q     <= layer_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ofmap_packetizer.sv
// Bench for ofmap_packetizer (3x3 frames): vector table, directed corner cases and
// randomized backpressure, checked against a queue model built from raster index arithmetic.
`timescale 1ns/1ps
module tb_ofmap_packetizer;

  localparam int DEPTH = 3;
  localparam int N     = DEPTH * DEPTH;
  localparam int SATV  = 8191;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  ts_in = 2'd0;
  logic [1:0]  layer_in = 2'd0;
  logic        busy;
  logic        done;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_psum = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] out_data;

  ofmap_packetizer #(
    .PACKET_D_WIDTH(40),
    .ADDR_WIDTH(5),
    .WIDTH_I(16),
    .WIDTH_O(13),
    .DEPTH_R(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ts_in(ts_in),
    .layer_in(layer_in),
    .busy(busy),
    .done(done),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_psum(in_psum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] psum;
    int          row;
    int          col;
    int          sat;
  } vec_t;

  vec_t        vecs[N];
  int          total = 0;
  int          bad = 0;
  logic [39:0] expQ[$];
  logic [39:0] expItem;
  int          acceptCount = 0;
  int          popCount = 0;
  int          donePulses = 0;
  logic        modelBusy = 1'b0;
  logic        expectDone = 1'b0;
  logic        stallPrev = 1'b0;
  logic [39:0] dataPrev = 40'd0;
  logic [1:0]  modelTs = 2'd0;
  logic [1:0]  modelLayer = 2'd0;
  logic        bpEnable = 1'b0;

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] modelPkt(input int idx, input logic [15:0] v,
                                           input logic [1:0] ts, input logic [1:0] lay);
    int sat;
    logic [4:0] r;
    logic [4:0] c;
    sat = (int'(v) > SATV) ? SATV : int'(v);
    r = 5'(idx / DEPTH);
    c = 5'(idx % DEPTH);
    return {r, c, ts, lay, 13'd0, 13'(sat)};
  endfunction

  function automatic logic [15:0] randPsum();
    if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 65535));
    return 16'($urandom_range(0, 9000));
  endfunction

  // Scoreboard: pops happen before pushes since a packet leaving this cycle
  // always belongs to an earlier input transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      stallPrev   = 1'b0;
      expectDone  = 1'b0;
      modelBusy   = 1'b0;
      acceptCount = 0;
      popCount    = 0;
    end else begin
      if (stallPrev) begin
        checkOutput("hold_valid", {39'd0, out_valid}, 40'd1);
        checkOutput("hold_data", out_data, dataPrev);
      end
      checkOutput("done", {39'd0, done}, {39'd0, expectDone});
      checkOutput("busy", {39'd0, busy}, {39'd0, modelBusy});
      if (done) donePulses++;
      expectDone = 1'b0;
      if (out_valid && !out_ready) checkOutput("ready_stall", {39'd0, in_ready}, 40'd0);
      if (!modelBusy || acceptCount >= N) checkOutput("ready_idle", {39'd0, in_ready}, 40'd0);
      if (out_valid && out_ready) begin
        checkOutput("pkt_avail", {39'd0, (expQ.size() != 0)}, 40'd1);
        if (expQ.size() != 0) begin
          expItem = expQ.pop_front();
          checkOutput("pkt", out_data, expItem);
          popCount++;
          if (popCount == N) begin
            modelBusy  = 1'b0;
            expectDone = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        checkOutput("accept_bound", {39'd0, (acceptCount < N)}, 40'd1);
        expQ.push_back(modelPkt(acceptCount, in_psum, modelTs, modelLayer));
        acceptCount++;
      end
      stallPrev = out_valid && !out_ready;
      dataPrev  = out_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (bpEnable) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic startFrame(input logic [1:0] ts, input logic [1:0] lay);
    start    = 1'b1;
    ts_in    = ts;
    layer_in = lay;
    @(posedge clk); #1;
    start       = 1'b0;
    ts_in       = 2'($urandom_range(0, 3));
    layer_in    = 2'($urandom_range(0, 3));
    modelTs     = ts;
    modelLayer  = lay;
    acceptCount = 0;
    popCount    = 0;
    modelBusy   = 1'b1;
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_psum  = v;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_psum  = 16'($urandom_range(0, 65535));
    checkOutput("accept_wait", {39'd0, got}, 40'd1);
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", {39'd0, seen}, 40'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    vecs[0] = '{16'd8191,  0, 0, 8191};
    vecs[1] = '{16'd8192,  0, 1, 8191};
    vecs[2] = '{16'hFFFF,  0, 2, 8191};
    vecs[3] = '{16'd0,     1, 0, 0};
    vecs[4] = '{16'd1,     1, 1, 1};
    vecs[5] = '{16'd8190,  1, 2, 8190};
    vecs[6] = '{16'd4096,  2, 0, 4096};
    vecs[7] = '{16'd8193,  2, 1, 8191};
    vecs[8] = '{16'd7,     2, 2, 7};

    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_psum   = 16'($urandom_range(0, 65535));
      ts_in     = 2'($urandom_range(0, 3));
      layer_in  = 2'($urandom_range(0, 3));
      @(negedge clk);
      checkOutput("rst_ctrl", {36'd0, busy, done, in_ready, out_valid}, 40'd0);
      checkOutput("rst_data", out_data, 40'd0);
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_ctrl", {36'd0, busy, done, in_ready, out_valid}, 40'd0);
      checkOutput("idle_data", out_data, 40'd0);
    end
    @(posedge clk); #1;

    $display("[TB] full frame, no stall");
    d0 = donePulses;
    startFrame(2'd2, 2'd1);
    for (int i = 1; i <= N; i++) begin
      applyStimulus(16'(i));
      if (i == 1) checkOutput("first_pkt", out_data, 40'h00_2400_0001);
    end
    waitDone();
    checkOutput("accepts", 40'(acceptCount), 40'(N));
    checkOutput("done_count", 40'(donePulses - d0), 40'd1);

    $display("[TB] saturation vector table");
    startFrame(2'd1, 2'd3);
    for (int i = 0; i < N; i++) begin
      applyStimulus(vecs[i].psum);
      checkOutput("tbl_pkt", out_data,
                  {5'(vecs[i].row), 5'(vecs[i].col), 2'd1, 2'd3, 13'd0, 13'(vecs[i].sat)});
    end
    waitDone();

    $display("[TB] random backpressure");
    bpEnable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      startFrame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
        applyStimulus(randPsum());
      end
      waitDone();
      checkOutput("bp_accepts", 40'(acceptCount), 40'(N));
    end
    bpEnable = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("[TB] start while busy");
    d0 = donePulses;
    startFrame(2'd0, 2'd2);
    for (int i = 0; i < N; i++) begin
      if (i == 4) begin
        start = 1'b1; ts_in = 2'd3; layer_in = 2'd0;
      end
      applyStimulus(randPsum());
      start = 1'b0;
    end
    waitDone();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("busy_start_done_count", 40'(donePulses - d0), 40'd1);

    $display("[TB] reset mid-frame");
    d0 = donePulses;
    startFrame(2'd3, 2'd3);
    for (int i = 0; i < 5; i++) applyStimulus(randPsum());
    out_ready = 1'b0;
    #1;
    checkOutput("pending_before_abort", {39'd0, out_valid}, 40'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ctrl", {36'd0, busy, done, in_ready, out_valid}, 40'd0);
    checkOutput("abort_data", out_data, 40'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 40'(donePulses - d0), 40'd0);
    startFrame(2'd1, 2'd1);
    applyStimulus(16'd100);
    checkOutput("restart_pkt", out_data, {5'd0, 5'd0, 2'd1, 2'd1, 13'd0, 13'd100});
    for (int i = 1; i < N; i++) applyStimulus(randPsum());
    waitDone();
    checkOutput("restart_accepts", 40'(acceptCount), 40'(N));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ofmap_packetizer.md
Name: ofmap_packetizer

Overview:
- Clocked transmitter at the far end of the ofmap packet link: takes a raster stream of accumulated partial sums from the PE array and emits one 40-bit ofmap packet per output neuron.
- Tags each packet with row, column, timestep and layer, saturating the sum to the residue width, so the downstream ofmap receiver can index its residue memory directly.
- Sits between the PE-array accumulator output and the NoC/ofmap channel.
- Runs one frame of DEPTH_R*DEPTH_R packets per start.

Parameters:
- PACKET_D_WIDTH, 40, packet width; the field layout below is fixed for 40.
- ADDR_WIDTH, 5, row/column field width.
- WIDTH_I, 16, incoming unsigned partial-sum width.
- WIDTH_O, 13, packet partial-sum field width.
- DEPTH_R, 21, output feature map side length (1..2^ADDR_WIDTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- ts_in  in  2  timestep tag, sampled on an accepted start.
- layer_in  in  2  layer tag, sampled on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last packet of a frame is accepted.
- in_valid  in  1  partial-sum valid.
- in_ready  out  1  partial-sum ready.
- in_psum  in  WIDTH_I  unsigned partial sum, raster order.
- out_valid  out  1  packet valid.
- out_ready  in  1  packet ready (downstream).
- out_data  out  PACKET_D_WIDTH  ofmap packet.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, in_ready and out_valid = 0; out_data = 0; row/col counters and packet counter = 0; ts/layer registers = 0.
- Handshake: a transfer occurs on a rising edge where valid and ready are both high.
  - While out_valid=1 and out_ready=0, out_valid and out_data hold stable.
  - Valid never depends combinationally on ready.
- Packet layout:
  - [39:35] row.
  - [34:30] col.
  - [29:28] ts.
  - [27:26] layer.
  - [25:13] zero.
  - [12:0] psum_sat, where psum_sat = min(in_psum, 2^WIDTH_O-1). Unsigned saturation, no wrap.
- Raster order is row-major with col fastest.
  - col increments per accepted input.
  - col wraps DEPTH_R-1 -> 0 with row+1.
  - The first packet is (0,0); the last is (DEPTH_R-1,DEPTH_R-1).
- Output stage: single register, 1-cycle latency from input transfer to out_valid.
  - in_ready = (state==RUN) && (!out_valid || out_ready), allowing one transfer per cycle at full throughput.
- FSM states:
  - IDLE: on start=1, latch ts_in and layer_in, clear counters, busy=1, go to RUN. Otherwise stay.
  - RUN: accept inputs. When the DEPTH_R*DEPTH_R-th input is accepted, go to DRAIN; in_ready=0 from the next cycle.
  - DRAIN: wait for the final packet to be accepted. On that edge go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Boundaries:
  - start in any state other than IDLE is ignored; the latched ts/layer do not change.
  - start coinciding with done (DONE state) is ignored; a new start is accepted only in IDLE.
  - in_valid while not in RUN is not accepted (in_ready=0), and the data is not consumed.
  - Counter widths hold DEPTH_R*DEPTH_R without overflow. After a frame, counters are left for the next start to clear.
  - Reset mid-frame aborts immediately:
    - any pending packet is dropped (out_valid=0);
    - no done pulse is generated;
    - the next frame restarts at (0,0).
  - in_psum = 2^WIDTH_O-1 exactly passes unchanged; any larger value clips to 8191.

Test Plan:
- Reset/idle: hold rst_n=0 with random inputs -> busy=0, done=0, in_ready=0, out_valid=0, out_data=0. Release rst_n with no start -> all remain 0.
- Full frame, no stall (DEPTH_R=3): start with ts_in=2, layer_in=1, then 9 psums 1..9 back-to-back with out_ready=1.
  - Expect 9 packets with (row,col) = (0,0),(0,1),(0,2),(1,0)...(2,2).
  - ts field=2, layer=1, psum=1..9; first packet out_data=40'h0000_0001 | ts/layer bits.
  - One done pulse one cycle after the last accept; exactly 9 in-accepts.
- Backpressure: during the frame toggle out_ready 0/1 randomly -> out_data stable while stalled, no packet lost or duplicated, order preserved. in_ready=0 whenever out_valid=1 and out_ready=0.
- Saturation: in_psum = 8191, 8192, 16'hFFFF, 0 -> psum fields 8191, 8191, 8191, 0.
- Start while busy: pulse start mid-frame with ts_in=3 -> no restart, packets keep the original ts, and a single done pulse at the frame end.
- Reset mid-frame: assert rst_n=0 after 4 packets with one packet pending -> outputs return to reset values and no done pulse. A new start then produces its first packet at (0,0).
